// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: accepts one 12-bit frame per handshake and shifts
// the enabled bits out LSB-first on tx, each held for CLKS_PER_BIT clocks.
module uart_tx_serializer #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] frame_in,
    input  logic        frame_valid,
    output logic        frame_ready,
    input  logic        data_length,
    input  logic        parity_en,
    input  logic        stop2,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Packs the enabled bits into transmit order; unused upper slots stay 1
    // so the forced stop level falls out naturally.
    function automatic logic [11:0] build_seq(input logic [11:0] f,
                                              input logic        dl,
                                              input logic        pe);
        logic [11:0] s;
        s      = 12'hFFF;
        s[0]   = 1'b0;
        s[7:1] = f[7:1];
        s[8]   = dl ? f[8] : (pe ? f[9] : 1'b1);
        s[9]   = (dl && pe) ? f[9] : 1'b1;
        return s;
    endfunction

    state_t        state_q, state_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [3:0]    idx_q, idx_d;
    logic [3:0]    last_q, last_d;
    logic [11:0]   seq_q, seq_d;
    logic          tx_q, tx_d;
    logic          ready_q, ready_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            idx_q   <= 4'd0;
            last_q  <= 4'd0;
            seq_q   <= 12'hFFF;
            tx_q    <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            seq_q   <= seq_d;
            tx_q    <= tx_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        idx_d   = idx_q;
        last_d  = last_q;
        seq_d   = seq_q;
        tx_d    = tx_q;
        ready_d = ready_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (frame_valid && ready_q) begin
                    state_d = SHIFT;
                    seq_d   = build_seq(frame_in, data_length, parity_en);
                    // Index of the final bit: N-1 = 8 + optional bits.
                    last_d  = 4'd8 + {3'b000, data_length} + {3'b000, parity_en}
                            + {3'b000, stop2};
                    baud_d  = '0;
                    idx_d   = 4'd0;
                    tx_d    = 1'b0;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                end else begin
                    tx_d    = 1'b1;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            SHIFT: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    if (idx_q == last_q) begin
                        state_d = IDLE;
                        idx_d   = 4'd0;
                        tx_d    = 1'b1;
                        ready_d = 1'b1;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 4'd1;
                        tx_d  = seq_q[idx_q + 4'd1];
                    end
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                baud_d  = '0;
                idx_d   = 4'd0;
                tx_d    = 1'b1;
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign tx          = tx_q;
    assign frame_ready = ready_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed self-checking bench for uart_tx_serializer with CLKS_PER_BIT = 4.
module tb_uart_tx_serializer;

    localparam int C = 4;

    logic        clk;
    logic        rst;
    logic [11:0] frame_in;
    logic        frame_valid;
    logic        frame_ready;
    logic        data_length;
    logic        parity_en;
    logic        stop2;
    logic        tx;
    logic        busy;
    logic        done;

    int total_checks;
    int failed_checks;

    uart_tx_serializer #(.CLKS_PER_BIT(C)) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_in    (frame_in),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .data_length (data_length),
        .parity_en   (parity_en),
        .stop2       (stop2),
        .tx          (tx),
        .busy        (busy),
        .done        (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic obs, input logic exp);
        total_checks++;
        assert (obs === exp) else begin
            failed_checks++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Called #1 after the accept edge; checks every cycle of every bit, then
    // the completion edge. Returns #1 after the edge where done is high.
    task automatic run_bits(input logic [11:0] exp, input int n, input bit toggle);
        for (int i = 0; i < n; i++) begin
            for (int c = 0; c < C; c++) begin
                @(negedge clk);
                if (toggle) begin
                    frame_in    = ~frame_in;
                    data_length = ~data_length;
                    parity_en   = ~parity_en;
                    stop2       = ~stop2;
                end
                chk($sformatf("tx bit%0d cyc%0d", i, c), tx, exp[i]);
                chk("busy in shift", busy, 1'b1);
                chk("ready in shift", frame_ready, 1'b0);
                chk("done early", done, 1'b0);
            end
        end
        @(posedge clk); #1;
        chk("done pulse", done, 1'b1);
        chk("tx idle at end", tx, 1'b1);
        chk("busy at end", busy, 1'b0);
        chk("ready at end", frame_ready, 1'b1);
    endtask

    task automatic accept(input logic [11:0] f, input logic dl, input logic pe,
                          input logic s2);
        @(negedge clk);
        frame_in    = f;
        data_length = dl;
        parity_en   = pe;
        stop2       = s2;
        frame_valid = 1'b1;
        @(posedge clk); #1;
        frame_valid = 1'b0;
        chk("accept busy", busy, 1'b1);
        chk("accept ready", frame_ready, 1'b0);
    endtask

    task automatic done_drops;
        @(posedge clk); #1;
        chk("done one cycle", done, 1'b0);
        chk("idle tx", tx, 1'b1);
    endtask

    initial begin
        total_checks  = 0;
        failed_checks = 0;
        rst         = 1'b1;
        frame_in    = 12'h000;
        frame_valid = 1'b0;
        data_length = 1'b1;
        parity_en   = 1'b1;
        stop2       = 1'b1;
        #12;
        chk("reset tx", tx, 1'b1);
        chk("reset ready", frame_ready, 1'b1);
        chk("reset busy", busy, 1'b0);
        chk("reset done", done, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Full 12-bit frame: 0,1,0,1,0,0,1,0,1,0,1,1
        accept(12'hD4A, 1'b1, 1'b1, 1'b1);
        run_bits(12'hD4A, 12, 1'b0);
        done_drops();

        // Shortest frame: 0,1,0,1,0,0,1,0,1
        accept(12'hD4A, 1'b0, 1'b0, 1'b0);
        run_bits(12'h14A, 9, 1'b0);
        done_drops();

        // Start bit forced low, stop bits forced high
        accept(12'h3FF, 1'b1, 1'b1, 1'b1);
        run_bits(12'hFFE, 12, 1'b0);
        done_drops();

        // Back-to-back with frame_valid held high
        @(negedge clk);
        frame_in    = 12'h0B5;
        data_length = 1'b1;
        parity_en   = 1'b0;
        stop2       = 1'b0;
        frame_valid = 1'b1;
        @(posedge clk); #1;
        chk("b2b A accept", busy, 1'b1);
        frame_in    = 12'h26C;
        data_length = 1'b0;
        parity_en   = 1'b1;
        stop2       = 1'b1;
        run_bits(12'h2B4, 10, 1'b0);
        @(negedge clk);
        chk("b2b idle gap tx", tx, 1'b1);
        chk("b2b idle gap ready", frame_ready, 1'b1);
        @(posedge clk); #1;
        chk("b2b B accept busy", busy, 1'b1);
        chk("b2b B start", tx, 1'b0);
        chk("b2b done dropped", done, 1'b0);
        frame_valid = 1'b0;
        run_bits(12'h76C, 11, 1'b0);
        done_drops();
        chk("b2b no extra accept", busy, 1'b0);

        // Reset during data bit 3, then accept on first edge after release
        accept(12'hD4A, 1'b1, 1'b1, 1'b1);
        repeat (3 * C + 1) @(negedge clk);
        chk("pre-reset busy", busy, 1'b1);
        rst = 1'b1;
        #1;
        chk("async reset tx", tx, 1'b1);
        chk("async reset busy", busy, 1'b0);
        chk("async reset ready", frame_ready, 1'b1);
        chk("async reset done", done, 1'b0);
        frame_in    = 12'h3FF;
        data_length = 1'b1;
        parity_en   = 1'b1;
        stop2       = 1'b1;
        frame_valid = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        frame_valid = 1'b0;
        chk("post-reset accept busy", busy, 1'b1);
        chk("post-reset start", tx, 1'b0);
        run_bits(12'hFFE, 12, 1'b0);
        done_drops();

        // Inputs toggling every cycle during SHIFT must not disturb the frame
        accept(12'h5A6, 1'b1, 1'b1, 1'b0);
        run_bits(12'h5A6, 11, 1'b1);
        done_drops();

        $display("%0d/%0d checks passed", total_checks - failed_checks, total_checks);
        $finish;
    end

endmodule
